// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation and vectoring engines.
// Both engines use the same binary-angle format: 0x4000 = 90 degrees.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        COMP,
        DONE
    } cordic_state_t;

    localparam logic [15:0] ANGLE_90     = 16'h4000;
    localparam logic [15:0] GAIN_INV_Q15 = 16'h4DBA;
    localparam int          GUARD_BITS   = 2;

endpackage

// File: rtl/cordic_microrotation.sv
// One combinational CORDIC micro-rotation step.
// The caller picks the direction, so rotation and vectoring engines can share this block.
module cordic_microrotation #(
    parameter int XY_WIDTH    = 18,
    parameter int ANGLE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic signed [XY_WIDTH-1:0]    x,
    input  logic signed [XY_WIDTH-1:0]    y,
    input  logic        [ANGLE_WIDTH-1:0] z,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic        [ANGLE_WIDTH-1:0] atan,
    input  logic                          counter_clockwise,
    output logic signed [XY_WIDTH-1:0]    x_next,
    output logic signed [XY_WIDTH-1:0]    y_next,
    output logic        [ANGLE_WIDTH-1:0] z_next
);

    logic signed [XY_WIDTH-1:0] x_shifted;
    logic signed [XY_WIDTH-1:0] y_shifted;

    always_comb begin
        x_shifted = x >>> shift;
        y_shifted = y >>> shift;
        if (counter_clockwise) begin
            x_next = x - y_shifted;
            y_next = y + x_shifted;
            z_next = z - atan;
        end else begin
            x_next = x + y_shifted;
            y_next = y - x_shifted;
            z_next = z + atan;
        end
    end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: rotates (x_in, y_in) by angle_in, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales the result by 1/K.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ANGLE_WIDTH    = 16,
    parameter int ADDRESS_LENGTH = 4,
    parameter int ITERATIONS     = 14
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic signed [DATA_WIDTH-1:0]            x_in,
    input  logic signed [DATA_WIDTH-1:0]            y_in,
    input  logic        [ANGLE_WIDTH-1:0]           angle_in,
    output logic                                    rom_read_enable,
    output logic        [ADDRESS_LENGTH-1:0]        rom_address,
    input  logic signed [DATA_WIDTH-1:0]            rom_data,
    output logic                                    busy,
    output logic                                    done,
    output logic signed [DATA_WIDTH+GUARD_BITS-1:0] x_out,
    output logic signed [DATA_WIDTH+GUARD_BITS-1:0] y_out,
    output logic        [ANGLE_WIDTH-1:0]           z_residual
);

    localparam int XY_WIDTH = DATA_WIDTH + GUARD_BITS;
    localparam logic [ANGLE_WIDTH-1:0] QUARTER_TURN = ANGLE_WIDTH'(ANGLE_90);

    cordic_state_t state;
    cordic_state_t next_state;

    logic        [ADDRESS_LENGTH-1:0] iter_count;
    logic signed [XY_WIDTH-1:0]       x_reg;
    logic signed [XY_WIDTH-1:0]       y_reg;
    logic        [ANGLE_WIDTH-1:0]    z_reg;
    logic signed [XY_WIDTH-1:0]       x_ext;
    logic signed [XY_WIDTH-1:0]       y_ext;
    logic signed [XY_WIDTH-1:0]       x_next;
    logic signed [XY_WIDTH-1:0]       y_next;
    logic        [ANGLE_WIDTH-1:0]    z_next;
    logic        [ANGLE_WIDTH-1:0]    atan;
    logic                             last_iter;
    logic                             accept;

    assign x_ext     = XY_WIDTH'(x_in);
    assign y_ext     = XY_WIDTH'(y_in);
    assign atan      = ANGLE_WIDTH'(rom_data);
    assign last_iter = (iter_count == ADDRESS_LENGTH'(ITERATIONS - 1));
    // The IDLE cycle that shows done must not start a new operation.
    assign accept    = (state == IDLE) && start && !done;

    cordic_microrotation #(
        .XY_WIDTH   (XY_WIDTH),
        .ANGLE_WIDTH(ANGLE_WIDTH),
        .SHIFT_WIDTH(ADDRESS_LENGTH)
    ) u_microrotation (
        .x                (x_reg),
        .y                (y_reg),
        .z                (z_reg),
        .shift            (iter_count),
        .atan             (atan),
        .counter_clockwise(~z_reg[ANGLE_WIDTH-1]),
        .x_next           (x_next),
        .y_next           (y_next),
        .z_next           (z_next)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PROD_WIDTH = XY_WIDTH + 17;
    localparam logic signed [16:0]           GAIN_MULT  = 17'(GAIN_INV_Q15);
    localparam logic signed [PROD_WIDTH-1:0] ROUND_HALF = PROD_WIDTH'(1) <<< 14;

    logic signed [PROD_WIDTH-1:0] x_prod;
    logic signed [PROD_WIDTH-1:0] y_prod;
    logic signed [XY_WIDTH-1:0]   x_scaled;
    logic signed [XY_WIDTH-1:0]   y_scaled;

    always_comb begin
        x_prod   = x_reg * GAIN_MULT + ROUND_HALF;
        y_prod   = y_reg * GAIN_MULT + ROUND_HALF;
        x_scaled = XY_WIDTH'(x_prod >>> 15);
        y_scaled = XY_WIDTH'(y_prod >>> 15);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        rom_read_enable = 1'b0;
        rom_address     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = ITER;
                end
            end
            ITER: begin
                rom_read_enable = 1'b1;
                rom_address     = iter_count;
                if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
                    next_state = COMP;
`else
                    next_state = DONE;
`endif
                end
            end
            COMP:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Quadrant pre-rotation keeps the residual angle inside the CORDIC convergence range.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iter_count <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            z_reg      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            z_residual <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy       <= 1'b1;
                        iter_count <= '0;
                        case (angle_in[ANGLE_WIDTH-1 -: 2])
                            2'b01: begin
                                x_reg <= -y_ext;
                                y_reg <= x_ext;
                                z_reg <= angle_in - QUARTER_TURN;
                            end
                            2'b10: begin
                                x_reg <= y_ext;
                                y_reg <= -x_ext;
                                z_reg <= angle_in + QUARTER_TURN;
                            end
                            default: begin
                                x_reg <= x_ext;
                                y_reg <= y_ext;
                                z_reg <= angle_in;
                            end
                        endcase
                    end
                end
                ITER: begin
                    x_reg      <= x_next;
                    y_reg      <= y_next;
                    z_reg      <= z_next;
                    iter_count <= iter_count + 1'b1;
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: begin
                    x_reg <= x_scaled;
                    y_reg <= y_scaled;
                end
`endif
                DONE: begin
                    x_out      <= x_reg;
                    y_out      <= y_reg;
                    z_residual <= z_reg;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Bench for cordic_rotator: directed angles, protocol corner cases and random vectors
// compared against a floating-point rotation model; follows CORDIC_GAIN_COMP_EN like the RTL.
`timescale 1ns/1ps
module tb_cordic_rotator;

    localparam int  DW     = 16;
    localparam int  AW     = 16;
    localparam int  AL     = 4;
    localparam int  ITERS  = 14;
    localparam int  XYW    = DW + 2;
    localparam int  BUDGET = 64;
    localparam real PI     = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LATENCY    = ITERS + 2;
    localparam real MODEL_GAIN = 1.0;
`else
    localparam int  LATENCY    = ITERS + 1;
    localparam real MODEL_GAIN = 1.6467602581210654;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic signed [DW-1:0]  x_in;
    logic signed [DW-1:0]  y_in;
    logic        [AW-1:0]  angle_in;
    logic                  rom_read_enable;
    logic        [AL-1:0]  rom_address;
    logic signed [DW-1:0]  rom_data;
    logic                  busy;
    logic                  done;
    logic signed [XYW-1:0] x_out;
    logic signed [XYW-1:0] y_out;
    logic        [AW-1:0]  z_residual;

    logic [DW-1:0] rom_table [16];

    int vectors     = 0;
    int miscompares = 0;
    int lat;
    int re_cycles;
    int addr_ok;
    int busy_ok;
    int obs_x;
    int obs_y;
    int obs_z;

    cordic_rotator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .x_in           (x_in),
        .y_in           (y_in),
        .angle_in       (angle_in),
        .rom_read_enable(rom_read_enable),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .busy           (busy),
        .done           (done),
        .x_out          (x_out),
        .y_out          (y_out),
        .z_residual     (z_residual)
    );

    assign rom_data = rom_table[rom_address];

    always #5 clk = ~clk;

    function automatic int round_int(input real r);
        return $rtoi((r >= 0.0) ? r + 0.5 : r - 0.5);
    endfunction

    // Ideal rotation of (x, y) by the binary angle, scaled by the engine's net gain.
    function automatic void model_rotate(input int xv, input int yv, input int av,
                                         output int ex, output int ey);
        int  sa;
        real a;
        sa = (av >= 32768) ? av - 65536 : av;
        a  = real'(sa) * PI / 32768.0;
        ex = round_int(MODEL_GAIN * (real'(xv) * $cos(a) - real'(yv) * $sin(a)));
        ey = round_int(MODEL_GAIN * (real'(xv) * $sin(a) + real'(yv) * $cos(a)));
    endfunction

    task automatic check_output(input string tag, input int observed, input int expected,
                                input int tol);
        int diff;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        vectors++;
        assert ((diff <= tol) === 1'b1)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d (+/-%0d)", tag, observed, expected, tol);
        end
    endtask

    // Launch one operation and watch it cycle by cycle until done (bounded).
    task automatic apply_stimulus(input int xv, input int yv, input int av, input int repulse_at);
        x_in     = DW'(xv);
        y_in     = DW'(yv);
        angle_in = AW'(av);
        start    = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        lat       = -1;
        re_cycles = 0;
        addr_ok   = 1;
        busy_ok   = 1;
        for (int n = 0; n <= BUDGET; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_ok = 0;
            if (rom_read_enable) begin
                if (int'(rom_address) != re_cycles) addr_ok = 0;
                re_cycles++;
            end else if (rom_address != '0) begin
                addr_ok = 0;
            end
            if (n == repulse_at) begin
                start    = 1'b1;
                x_in     = ~x_in;
                angle_in = angle_in + 16'h1234;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        obs_x = int'(x_out);
        obs_y = int'(y_out);
        obs_z = int'(signed'(z_residual));
    endtask

    task automatic run_and_check(input string tag, input int xv, input int yv, input int av,
                                 input int tol, input int repulse_at);
        int ex;
        int ey;
        model_rotate(xv, yv, av, ex, ey);
        apply_stimulus(xv, yv, av, repulse_at);
        check_output({tag, " latency"}, lat, LATENCY, 0);
        check_output({tag, " x_out"}, obs_x, ex, tol);
        check_output({tag, " y_out"}, obs_y, ey, tol);
        check_output({tag, " z_residual"}, obs_z, 0, 3);
        check_output({tag, " rom reads"}, re_cycles, ITERS, 0);
        check_output({tag, " rom address order"}, addr_ok, 1, 0);
        check_output({tag, " busy continuous"}, busy_ok, 1, 0);
        @(posedge clk); #1;
        check_output({tag, " done one-cycle"}, int'(done), 0, 0);
    endtask

    initial begin
        int done_seen;
        for (int i = 0; i < 16; i++) begin
            rom_table[i] = DW'(round_int($atan(1.0 / (2.0 ** i)) * 32768.0 / PI));
        end
        rst_n    = 1'b0;
        start    = 1'b0;
        x_in     = '0;
        y_in     = '0;
        angle_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy", int'(busy), 0, 0);
        check_output("reset done", int'(done), 0, 0);
        check_output("reset rom_read_enable", int'(rom_read_enable), 0, 0);
        check_output("reset rom_address", int'(rom_address), 0, 0);
        check_output("reset x_out", int'(x_out), 0, 0);
        check_output("reset y_out", int'(y_out), 0, 0);
        check_output("reset z_residual", int'(z_residual), 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_and_check("zero angle", 16384, 0, 16'h0000, 4, -1);
        run_and_check("90 deg", 16384, 0, 16'h4000, 4, -1);
        run_and_check("45 deg", 10000, 0, 16'h2000, 4, -1);
        run_and_check("-180 deg", -32768, 0, 16'h8000, 6, -1);
        run_and_check("-135 deg", 12000, -7000, 16'hA000, 6, -1);
        run_and_check("start repulse", 12000, 5000, 16'h3000, 6, 5);

        // Abort at iteration 7: outputs clear, no done follows.
        x_in     = DW'(9000);
        y_in     = DW'(3000);
        angle_in = 16'h1800;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_output("abort busy", int'(busy), 0, 0);
        check_output("abort done", int'(done), 0, 0);
        check_output("abort rom_read_enable", int'(rom_read_enable), 0, 0);
        check_output("abort rom_address", int'(rom_address), 0, 0);
        check_output("abort x_out", int'(x_out), 0, 0);
        check_output("abort y_out", int'(y_out), 0, 0);
        check_output("abort z_residual", int'(z_residual), 0, 0);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check_output("abort no done", done_seen, 0, 0);

        for (int k = 0; k < 24; k++) begin
            int xv;
            int yv;
            int av;
            xv = int'($urandom_range(0, 32000)) - 16000;
            yv = int'($urandom_range(0, 32000)) - 16000;
            av = int'($urandom_range(0, 65535));
            run_and_check($sformatf("random %0d", k), xv, yv, av, 20, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
